dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
Two-requester arbiter and sequencer in front of the byte-addressed 1 KB data memory. Port 0 is the pipeline MEM stage and has priority. Port 1 is a secondary master (loader/debug) and is protected by a starvation guard. The block registers the winning command, drives the memory command bus for exactly one cycle, captures read data and returns a one-cycle ack to the winner.

Parameters:
DATA_W, 32, data and address width
MEM_DEPTH, 1024, memory size in bytes; used for the range check
STARVE_LIMIT, 4, consecutive lost arbitrations by port 1 before it is force-granted

Ports:
clk  in  1  clock; memory writes on posedge and reads on negedge of this clock
rst  in  1  synchronous active-high reset
req0  in  1  port 0 request; held high with stable cmd fields until ack0
rw0  in  2  port 0 command: 2'b10 read, 2'b01 write; 00/11 illegal
wb0  in  1  port 0 size: 0 word, 1 byte
addr0  in  DATA_W  port 0 byte address
wdata0  in  DATA_W  port 0 store data
ack0  out  1  one-cycle completion pulse to port 0
rdata0  out  DATA_W  port 0 read data, valid while ack0
err0  out  1  port 0 error, valid while ack0
stall0  out  1  req0 & ~ack0; pipeline hold
req1, rw1, wb1, addr1, wdata1, ack1, rdata1, err1  same as port 0, for port 1
mem_addr  out  DATA_W  to memory address
mem_wdata  out  DATA_W  to memory write_data
mem_rw  out  2  to memory Mem_Write_Read
mem_wb  out  1  to memory word_byte
mem_rdata  in  DATA_W  from memory Read_data

Behaviour:
- Reset (rst high at posedge): state IDLE; ack0/ack1/err0/err1 = 0; rdata0/rdata1 = 0; mem_rw = 2'b00; mem_addr/mem_wdata/mem_wb = 0; starve counter = 0. Memory contents are not touched.
- FSM states: IDLE, ISSUE, RESP. All outputs except stall0 are registered.
- IDLE:
  - No request: stay in IDLE.
  - Otherwise pick a winner and latch its rw/wb/addr/wdata and the winner ID; go to ISSUE.
  - Arbitration: port 0 wins if req0, unless req1 and starve counter = STARVE_LIMIT, in which case port 1 wins.
  - rw of 00 or 11 is latched as an error: no memory command is issued, and ack is returned with err=1.
- ISSUE: mem_rw/mem_addr/mem_wdata/mem_wb are driven from the latched command for exactly this one cycle.
  - Write commits at the closing posedge.
  - Read data from the negedge is captured at the closing posedge.
  - Next state is RESP; mem_rw returns to 00 in RESP.
- RESP: the winner's ack is 1 for one cycle, its rdata holds the captured value (writes return 0), and its err is set as computed. Next state is IDLE.
- Latency: request accepted at posedge N, memory cycle N+1, ack in cycle N+2; throughput is one access per 3 cycles. A requester must drop or change req in the cycle after ack; IDLE re-samples then.
- Byte read: the memory zero-extends (rdata[31:8] = 0).
- Byte store writes wdata[7:0] to addr.
- Word access is big-endian: addr gets bits 31:24, addr+3 gets bits 7:0.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) when req1 is high and port 0 wins an IDLE arbitration.
  - Clears when port 1 is granted, or when req1 is low in IDLE.
- Simultaneous req0 and req1 with counter below the limit: port 0 wins, port 1 keeps waiting and stays pending with no ack.
- Reset during ISSUE: the command already on the bus in that cycle may commit to memory. No ack is delivered, and the FSM returns to IDLE.
- Reset during RESP: the ack is suppressed.

Optional Feature:
DMEM_ARB_ERR_CHECK_EN:
- Defined: at IDLE latch, the command is flagged as an error if either condition holds:
  - word access with addr[1:0] != 0;
  - addr + (wb ? 0 : 3) >= MEM_DEPTH.
  - An error command skips the memory drive (mem_rw stays 00 in ISSUE) and acks with err=1 and rdata=0.
- Undefined: only illegal rw codes raise err; the address goes to the memory unchecked, and the memory uses addr[9:0].

Decomposition:
- Package dmem_pkg holds:
  - MEM_NOP=2'b00, MEM_WRITE=2'b01, MEM_READ=2'b10;
  - SZ_WORD=1'b0, SZ_BYTE=1'b1;
  - FSM state enum {IDLE, ISSUE, RESP}.
- No sub-module: the arbitration, counter and FSM stay flat in dmem_arbiter.

Test Plan:
- Word store then load on port 0: req0, rw0=01, wb0=0, addr0=0x10, wdata0=0xDEADBEEF. Then rw0=10 at the same address gives ack0 two cycles after acceptance with rdata0=0xDEADBEEF; mem_rw=01 is seen for exactly one cycle.
- Byte load on port 1: addr1=0x13 after reset-time init (byte 19 = 20) gives rdata1=0x00000014, err1=0.
- Contention: req0 and req1 held continuously with STARVE_LIMIT=4 gives grants 0,0,0,0,1,0,0,0,0,1; ack1 after every 4 port-0 acks.
- Illegal command: rw0=11 gives ack0 with err0=1, mem_rw stays 00 throughout, and memory is unchanged.
- With DMEM_ARB_ERR_CHECK_EN: word read at addr0=0x3FE or addr0=0x05 gives err0=1 with no memory cycle. Without the macro, the 0x05 read proceeds with err0=0.
- rst asserted in RESP of a port-0 read: no ack0, all outputs return to reset values; the next req0 completes normally.

Source files
------------

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory arbiter:
//   - memory command codes driven on mem_rw (MEM_NOP / MEM_WRITE / MEM_READ)
//   - access size codes driven on mem_wb (SZ_WORD / SZ_BYTE)
//   - the sequencer state encoding (IDLE, ISSUE, RESP)
//   - rw_legal(): true only for the two command codes the memory understands
// -----------------------------------------------------------------------------
package dmem_pkg;

   localparam logic [1:0] MEM_NOP   = 2'b00;
   localparam logic [1:0] MEM_WRITE = 2'b01;
   localparam logic [1:0] MEM_READ  = 2'b10;

   localparam logic SZ_WORD = 1'b0;
   localparam logic SZ_BYTE = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   // 2'b00 and 2'b11 are not commands; they are answered with an error ack.
   function automatic logic rw_legal(input logic [1:0] rw);
      return (rw == MEM_WRITE) || (rw == MEM_READ);
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles the two requester ports and the memory command bus of the data-memory
// arbiter.
//   Port p (p = 0, 1):
//     reqp    requester -> arbiter  request, held with stable fields until ackp
//     rwp     requester -> arbiter  2'b10 read, 2'b01 write, 00/11 illegal
//     wbp     requester -> arbiter  0 word, 1 byte
//     addrp   requester -> arbiter  byte address
//     wdatap  requester -> arbiter  store data
//     ackp    arbiter -> requester  one-cycle completion pulse
//     rdatap  arbiter -> requester  read data, valid while ackp
//     errp    arbiter -> requester  error flag, valid while ackp
//   stall0    arbiter -> port 0     req0 & ~ack0 (pipeline hold)
//   Memory bus:
//     mem_addr/mem_wdata/mem_rw/mem_wb  arbiter -> memory
//     mem_rdata                         memory  -> arbiter
// Modports: slave = the arbiter's view, master = requesters plus memory.
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
   parameter int DATA_W = 32
);
   logic              req0;
   logic [1:0]        rw0;
   logic              wb0;
   logic [DATA_W-1:0] addr0;
   logic [DATA_W-1:0] wdata0;
   logic              ack0;
   logic [DATA_W-1:0] rdata0;
   logic              err0;
   logic              stall0;

   logic              req1;
   logic [1:0]        rw1;
   logic              wb1;
   logic [DATA_W-1:0] addr1;
   logic [DATA_W-1:0] wdata1;
   logic              ack1;
   logic [DATA_W-1:0] rdata1;
   logic              err1;

   logic [DATA_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [1:0]        mem_rw;
   logic              mem_wb;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  req0, rw0, wb0, addr0, wdata0,
      output ack0, rdata0, err0, stall0,
      input  req1, rw1, wb1, addr1, wdata1,
      output ack1, rdata1, err1,
      output mem_addr, mem_wdata, mem_rw, mem_wb,
      input  mem_rdata
   );

   modport master (
      output req0, rw0, wb0, addr0, wdata0,
      input  ack0, rdata0, err0, stall0,
      output req1, rw1, wb1, addr1, wdata1,
      input  ack1, rdata1, err1,
      input  mem_addr, mem_wdata, mem_rw, mem_wb,
      output mem_rdata
   );

endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Two-requester arbiter and sequencer in front of the byte-addressed data
// memory. Port 0 (pipeline MEM stage) has priority; port 1 (loader/debug) is
// force-granted after STARVE_LIMIT consecutive lost arbitrations.
// Each access takes three cycles: IDLE latches the winner, ISSUE drives the
// memory bus for exactly one cycle (write commits / read data captured at its
// closing edge), RESP presents a one-cycle ack to the winner.
//
// Ports:
//   clk  clock (memory writes on posedge, reads on negedge)
//   rst  synchronous active-high reset
//   bus  dmem_arbiter_if.slave: both requester ports and the memory bus
//
// Build option:
//   DMEM_ARB_ERR_CHECK_EN  when defined, misaligned word accesses and accesses
//                          reaching past MEM_DEPTH are answered with err=1 and
//                          never reach the memory. When undefined, only illegal
//                          rw codes raise err.
// -----------------------------------------------------------------------------
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int MEM_DEPTH    = 1024,
   parameter int STARVE_LIMIT = 4
) (
   input  logic            clk,
   input  logic            rst,
   dmem_arbiter_if.slave   bus
);

`ifdef DMEM_ARB_ERR_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   // ---------------------------------------------------------------- state
   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  starve_reg, starve_next;

   // latched command of the current winner
   logic [1:0]        cmd_rw_reg;
   logic              cmd_err_reg;
   logic              cmd_port_reg;

   // memory command bus
   logic [DATA_W-1:0] mem_addr_reg;
   logic [DATA_W-1:0] mem_wdata_reg;
   logic [1:0]        mem_rw_reg;
   logic              mem_wb_reg;

   // per-port response registers
   logic              ack_reg   [2];
   logic              err_reg   [2];
   logic [DATA_W-1:0] rdata_reg [2];

   // ---------------------------------------------------------- arbitration
   logic              any_req;
   logic              grant1;
   logic [1:0]        sel_rw;
   logic              sel_wb;
   logic [DATA_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [DATA_W:0]   span_end;
   logic              range_err;
   logic              sel_err;

   always_comb begin
      any_req = bus.req0 | bus.req1;
      // Port 1 wins when alone, or when it has been starved long enough.
      grant1  = bus.req1 & (~bus.req0 | (starve_reg == CNT_MAX));

      sel_rw    = grant1 ? bus.rw1    : bus.rw0;
      sel_wb    = grant1 ? bus.wb1    : bus.wb0;
      sel_addr  = grant1 ? bus.addr1  : bus.addr0;
      sel_wdata = grant1 ? bus.wdata1 : bus.wdata0;

      // Last byte touched by the access, computed one bit wider so an address
      // near the top of the range cannot wrap and look in-bounds.
      span_end  = {1'b0, sel_addr} + ((sel_wb == SZ_BYTE) ? (DATA_W+1)'(0) : (DATA_W+1)'(3));
      range_err = ((sel_wb == SZ_WORD) && (sel_addr[1:0] != 2'b00)) ||
                  (span_end >= (DATA_W+1)'(MEM_DEPTH));

      sel_err   = ~rw_legal(sel_rw) | (CHECK_EN & range_err);
   end

   // ------------------------------------------------ next-state / counter
   always_comb begin
      state_next  = state_reg;
      starve_next = starve_reg;
      case (state_reg)
         IDLE: begin
            if (any_req) begin
               state_next = ISSUE;
            end
            // The counter tracks consecutive IDLE arbitrations port 1 lost.
            if (!bus.req1 || grant1) begin
               starve_next = '0;
            end else if (starve_reg != CNT_MAX) begin
               starve_next = starve_reg + CNT_W'(1);
            end
         end
         ISSUE:   state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ---------------------------------------------- state and command regs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         starve_reg    <= '0;
         cmd_rw_reg    <= MEM_NOP;
         cmd_err_reg   <= 1'b0;
         cmd_port_reg  <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
         mem_rw_reg    <= MEM_NOP;
         mem_wb_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         starve_reg <= starve_next;
         case (state_reg)
            IDLE: begin
               if (any_req) begin
                  cmd_rw_reg    <= sel_rw;
                  cmd_err_reg   <= sel_err;
                  cmd_port_reg  <= grant1;
                  mem_addr_reg  <= sel_addr;
                  mem_wdata_reg <= sel_wdata;
                  mem_wb_reg    <= sel_wb;
                  // An erroneous command never reaches the memory.
                  mem_rw_reg    <= sel_err ? MEM_NOP : sel_rw;
               end
            end
            ISSUE: begin
               mem_rw_reg <= MEM_NOP;
            end
            default: begin
               mem_rw_reg <= MEM_NOP;
            end
         endcase
      end
   end

   // -------------------------------------------------- per-port responses
   // The response for the winning port is loaded at the closing edge of
   // ISSUE, so it is visible exactly during RESP and cleared afterwards.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_resp
         always_ff @(posedge clk) begin
            if (rst) begin
               ack_reg[gi]   <= 1'b0;
               err_reg[gi]   <= 1'b0;
               rdata_reg[gi] <= '0;
            end else if ((state_reg == ISSUE) && (cmd_port_reg == 1'(gi))) begin
               ack_reg[gi]   <= 1'b1;
               err_reg[gi]   <= cmd_err_reg;
               rdata_reg[gi] <= ((cmd_rw_reg == MEM_READ) && !cmd_err_reg) ? bus.mem_rdata : '0;
            end else begin
               ack_reg[gi]   <= 1'b0;
               err_reg[gi]   <= 1'b0;
               rdata_reg[gi] <= '0;
            end
         end
      end
   endgenerate

   // ------------------------------------------------------------- outputs
   // A reset raised while the ack is on the bus hides it immediately so the
   // requester never sees a completion for an access that is being abandoned.
   assign bus.ack0   = ack_reg[0] & ~rst;
   assign bus.err0   = err_reg[0] & ~rst;
   assign bus.rdata0 = rdata_reg[0];
   assign bus.ack1   = ack_reg[1] & ~rst;
   assign bus.err1   = err_reg[1] & ~rst;
   assign bus.rdata1 = rdata_reg[1];
   assign bus.stall0 = bus.req0 & ~bus.ack0;

   assign bus.mem_addr  = mem_addr_reg;
   assign bus.mem_wdata = mem_wdata_reg;
   assign bus.mem_rw    = mem_rw_reg;
   assign bus.mem_wb    = mem_wb_reg;

endmodule
